sequential_or: RTL and testbench

Clocked, handshaked counterpart to the combinational recursive OR tree.
- Accepts two 2^S-bit operands and registers their bitwise OR.
- Reduces that word to a single "any bit set" flag by iterative halving, one tree level per clock. This reuses one level of OR gates instead of S levels.
- Sits between a valid/ready producer and consumer in datapaths where the combinational tree depth is too long for the clock.

---
 rtl/sequential_or_pkg.sv | 14 +
 rtl/or_fold_stage.sv | 27 ++
 rtl/sequential_or.sv | 104 ++++++++++
 tb/tb_sequential_or.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sequential_or_pkg.sv
// Shared state encoding and sizing helpers for the sequential OR reducer.
package sequential_or_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int step_w(int s);
    return (s > 0) ? s : 1;
  endfunction

endpackage

// File: rtl/or_fold_stage.sv
// One level of the OR tree: folds the upper live half onto the lower half.
module or_fold_stage
  import sequential_or_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]                       fold_i,
  input  logic [step_w($clog2(W))-1:0]       step_i,
  output logic [W-1:0]                       fold_o
);

  localparam int S  = $clog2(W);
  localparam int SW = step_w(S);

  // Bits at and above the new half width stay zero.
  always_comb begin
    fold_o = '0;
    for (int k = 0; k < S; k++) begin
      if (step_i == SW'(k)) begin
        for (int i = 0; i < (W >> (k + 1)); i++) begin
          fold_o[i] = fold_i[i] | fold_i[i + (W >> (k + 1))];
        end
      end
    end
  end

endmodule

// File: rtl/sequential_or.sv
// Handshaked OR of two operands, reduced to one flag a tree level per clock.
module sequential_or
  import sequential_or_pkg::*;
#(
  parameter int S = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [(1<<S)-1:0]   in1,
  input  logic [(1<<S)-1:0]   in2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [(1<<S)-1:0]   vec_out,
  output logic                any_out,
  output logic                busy
);

  localparam int W  = 1 << S;
  localparam int SW = step_w(S);

  state_e         state_q;
  logic [W-1:0]   vec_q;
  logic [W-1:0]   fold_q;
  logic [W-1:0]   fold_d;
  logic [SW-1:0]  step_q;
  logic           any_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic [W-1:0]   or_in;

  assign or_in = in1 | in2;

  or_fold_stage #(.W(W)) u_fold (
    .fold_i (fold_q),
    .step_i (step_q),
    .fold_o (fold_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      fold_q      <= '0;
      step_q      <= '0;
      any_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            vec_q      <= or_in;
            fold_q     <= or_in;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (S > 0) begin
              state_q <= FOLD;
            end else begin
              state_q     <= DONE;
              any_q       <= or_in[0];
              out_valid_q <= 1'b1;
            end
          end
        end
        FOLD: begin
          fold_q <= fold_d;
          step_q <= step_q + SW'(1);
          // On the last level fold_d[0] is fold[0] | fold[1].
          if (step_q == SW'(S - 1)) begin
            any_q       <= fold_d[0];
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign vec_out   = vec_q;
  assign any_out   = any_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sequential_or.sv
// Directed bench for sequential_or: S=3 and S=0 instances on one clock.
module tb_sequential_or;

  logic       clk;
  logic       reset;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in1, a_in2, a_vec;
  logic       a_any, a_busy;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [0:0] b_in1, b_in2, b_vec;
  logic       b_any, b_busy;

  int errors = 0;
  int checks = 0;

  sequential_or #(.S(3)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in1       (a_in1),
    .in2       (a_in2),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .vec_out   (a_vec),
    .any_out   (a_any),
    .busy      (a_busy)
  );

  sequential_or #(.S(0)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in1       (b_in1),
    .in2       (b_in2),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .vec_out   (b_vec),
    .any_out   (b_any),
    .busy      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_idle_state(string tag);
    chk({tag, " out_valid"}, 32'(a_out_valid), 0);
    chk({tag, " in_ready"},  32'(a_in_ready),  1);
    chk({tag, " busy"},      32'(a_busy),      0);
  endtask

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_in1 = '0; a_in2 = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in1 = '0; b_in2 = '0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    a_idle_state("rst");
    chk("rst vec", 32'(a_vec), 0);
    chk("rst any", 32'(a_any), 0);
    chk("rst b in_ready", 32'(b_in_ready), 1);
    chk("rst b out_valid", 32'(b_out_valid), 0);

    // 1: 252 | 1, four edges counting the accept edge
    a_in1 = 8'd252; a_in2 = 8'd1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("t1 accept out_valid", 32'(a_out_valid), 0);
    chk("t1 accept in_ready", 32'(a_in_ready), 0);
    chk("t1 accept busy", 32'(a_busy), 1);
    chk("t1 vec early", 32'(a_vec), 253);
    tick();
    tick();
    chk("t1 edge3 out_valid", 32'(a_out_valid), 0);
    tick();
    chk("t1 edge4 out_valid", 32'(a_out_valid), 1);
    chk("t1 vec", 32'(a_vec), 253);
    chk("t1 any", 32'(a_any), 1);
    tick();
    a_idle_state("t1 post");

    // 2: MSB propagates through every level
    a_in1 = 8'd128; a_in2 = 8'd0; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("t2 fold0", 32'(dut_a.fold_q), 32'h80);
    tick();
    chk("t2 fold1", 32'(dut_a.fold_q), 32'h08);
    tick();
    chk("t2 fold2", 32'(dut_a.fold_q), 32'h02);
    tick();
    chk("t2 fold3", 32'(dut_a.fold_q), 32'h01);
    chk("t2 out_valid", 32'(a_out_valid), 1);
    chk("t2 vec", 32'(a_vec), 128);
    chk("t2 any", 32'(a_any), 1);
    tick();

    // 3: zero result then back-to-back 0x01
    a_in1 = 8'd0; a_in2 = 8'd0; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick(); tick(); tick();
    chk("t3a out_valid", 32'(a_out_valid), 1);
    chk("t3a vec", 32'(a_vec), 0);
    chk("t3a any", 32'(a_any), 0);
    tick();
    chk("t3 in_ready", 32'(a_in_ready), 1);
    a_in1 = 8'h01; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick(); tick(); tick();
    chk("t3b out_valid", 32'(a_out_valid), 1);
    chk("t3b vec", 32'(a_vec), 1);
    chk("t3b any", 32'(a_any), 1);
    tick();

    // 4: backpressure holds outputs, ignores new operands
    a_out_ready = 1'b0;
    a_in1 = 8'h30; a_in2 = 8'h03; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick(); tick(); tick();
    chk("t4 out_valid", 32'(a_out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      a_in1 = 8'hFF; a_in2 = 8'h00; a_in_valid = 1'b1;
      tick();
      chk("t4 hold vec", 32'(a_vec), 32'h33);
      chk("t4 hold any", 32'(a_any), 1);
      chk("t4 hold out_valid", 32'(a_out_valid), 1);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    a_idle_state("t4 release");
    chk("t4 vec kept", 32'(a_vec), 32'h33);

    // 5: reset during FOLD step 1 aborts
    a_in1 = 8'h04; a_in2 = 8'h00; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    chk("t5 step", 32'(dut_a.step_q), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_idle_state("t5 abort");
    chk("t5 vec", 32'(a_vec), 0);
    chk("t5 any", 32'(a_any), 0);
    a_in1 = 8'h40; a_in2 = 8'h02; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick(); tick(); tick();
    chk("t5 new out_valid", 32'(a_out_valid), 1);
    chk("t5 new vec", 32'(a_vec), 32'h42);
    chk("t5 new any", 32'(a_any), 1);
    tick();

    // 6: S=0 instance
    b_in1 = 1'b1; b_in2 = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b0;
    tick();
    b_in_valid = 1'b0;
    chk("t6a out_valid", 32'(b_out_valid), 1);
    chk("t6a any", 32'(b_any), 1);
    chk("t6a vec", 32'(b_vec), 1);
    chk("t6a in_ready", 32'(b_in_ready), 0);
    b_out_ready = 1'b1;
    tick();
    chk("t6a post out_valid", 32'(b_out_valid), 0);
    chk("t6a post in_ready", 32'(b_in_ready), 1);
    b_in1 = 1'b0; b_in2 = 1'b0; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    chk("t6b out_valid", 32'(b_out_valid), 1);
    chk("t6b any", 32'(b_any), 0);
    chk("t6b vec", 32'(b_vec), 0);
    tick();
    chk("t6b post out_valid", 32'(b_out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
